reg_dump_streamer: RTL and testbench

Debug reader for the pipelined CPU's register file. On a `start` pulse it walks the register file's debug read port (`registerswitch`/`registerout`) from `FIRST_REG` to `LAST_REG`, snapshots each 32-bit value and streams it out as bytes over a valid/ready interface. That interface feeds the board's UART transmitter. It sits beside the CPU core, is clocked by the CPU `clock`, and never touches the pipeline read/write ports.

---
 rtl/reg_dump_pkg.sv | 32 +++
 rtl/reg_dump_serializer.sv | 78 +++++++
 rtl/reg_dump_streamer.sv | 93 +++++++++
 tb/tb_reg_dump_streamer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump streamer.
// The optional header byte (REG_DUMP_HEADER_EN) is built with hdr_byte().
package reg_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_HDR,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [2:0] HDR_TAG       = 3'b101;
    localparam int         BYTES_PER_REG = 4;
    localparam int         NUM_REGS      = 32;
    localparam int         IDX_W         = $clog2(NUM_REGS);
    localparam logic [1:0] LAST_BYTE     = 2'(BYTES_PER_REG - 1);

    // Byte of a latched word for a given send position; MSB-first walks 3,2,1,0.
    function automatic logic [7:0] word_byte(input logic [31:0] word,
                                             input logic [1:0]  cnt,
                                             input bit          msb_first);
        logic [1:0] sel;
        sel = msb_first ? ~cnt : cnt;
        return word[{sel, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [IDX_W-1:0] idx);
        return {HDR_TAG, idx};
    endfunction

endpackage

// File: rtl/reg_dump_serializer.sv
// Latches one register word and serializes it into bytes over valid/ready.
// With REG_DUMP_HEADER_EN defined, a tag+index header byte precedes each word.
module reg_dump_serializer
    import reg_dump_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [31:0]      i_word,
`ifdef REG_DUMP_HEADER_EN
    input  logic [IDX_W-1:0] i_index,
`endif
    input  logic             i_ready,
    output logic [7:0]       o_data,
    output logic             o_valid,
    output logic             o_last_byte
);

    logic [31:0] r_word;
    logic [1:0]  r_cnt;
    logic        r_valid;
    logic        w_accept;
    logic        w_in_hdr;
    logic [7:0]  w_hdr_byte;

    assign w_accept = r_valid && i_ready;

`ifdef REG_DUMP_HEADER_EN
    logic r_hdr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hdr <= 1'b0;
        end else if (i_load) begin
            r_hdr <= 1'b1;
        end else if (w_accept) begin
            r_hdr <= 1'b0;
        end
    end

    assign w_in_hdr   = r_hdr;
    assign w_hdr_byte = hdr_byte(i_index);
`else
    assign w_in_hdr   = 1'b0;
    assign w_hdr_byte = 8'h00;
`endif

    // Snapshot taken only on load, so later register-file writes cannot leak in.
    always_ff @(posedge clock) begin
        if (i_load) begin
            r_word <= i_word;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= 2'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_cnt   <= 2'd0;
            r_valid <= 1'b1;
        end else if (w_accept && !w_in_hdr) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == LAST_BYTE) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = !r_valid ? 8'h00 :
                         w_in_hdr ? w_hdr_byte :
                         word_byte(r_word, r_cnt, MSB_FIRST != 0);
    assign o_last_byte = w_accept && !w_in_hdr && (r_cnt == LAST_BYTE);

endmodule

// File: rtl/reg_dump_streamer.sv
// Walks the register-file debug port FIRST_REG..LAST_REG and streams each word as bytes.
// Define REG_DUMP_HEADER_EN to prefix every word with a {3'b101, index} header byte.
module reg_dump_streamer
    import reg_dump_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] registerswitch,
    input  logic [31:0]      registerout,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

    state_t           r_state;
    logic [IDX_W-1:0] r_index;
    logic             w_load;
    logic             w_last_byte;

    assign w_load = (r_state == ST_SELECT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_index <= FIRST_IDX;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_index <= FIRST_IDX;
                    if (start) begin
                        r_state <= ST_SELECT;
                    end
                end
`ifdef REG_DUMP_HEADER_EN
                ST_SELECT: r_state <= ST_HDR;
                ST_HDR: begin
                    if (tx_valid && tx_ready) begin
                        r_state <= ST_SEND;
                    end
                end
`else
                ST_SELECT: r_state <= ST_SEND;
`endif
                ST_SEND: begin
                    if (w_last_byte) begin
                        if (r_index == LAST_IDX) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_index <= r_index + IDX_W'(1);
                            r_state <= ST_SELECT;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_index <= FIRST_IDX;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_DONE);
    assign registerswitch = r_index;

    reg_dump_serializer #(
        .MSB_FIRST (MSB_FIRST)
    ) u_serializer (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_word      (registerout),
`ifdef REG_DUMP_HEADER_EN
        .i_index     (r_index),
`endif
        .i_ready     (tx_ready),
        .o_data      (tx_data),
        .o_valid     (tx_valid),
        .o_last_byte (w_last_byte)
    );

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Self-checking bench for reg_dump_streamer against a byte-stream reference model.
// Adapts its expectations when REG_DUMP_HEADER_EN is defined.
module tb_reg_dump_streamer;

`ifdef REG_DUMP_HEADER_EN
    localparam int BPR = 5;
`else
    localparam int BPR = 4;
`endif
    localparam int CPR      = BPR + 1;
    localparam int TOTAL    = 32 * BPR;
    localparam int DONE_CYC = 32 * CPR + 1;
    localparam int WOFF     = BPR - 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  registerswitch;
    logic [31:0] registerout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic [31:0] rf [32];
    assign registerout = rf[registerswitch];

    reg_dump_streamer #(
        .FIRST_REG (0),
        .LAST_REG  (31),
        .MSB_FIRST (1)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .registerswitch (registerswitch),
        .registerout    (registerout),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
    );

    always #5 clock = ~clock;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int cyc0 = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int d_before = 0;
    int stall_cnt = 0;
    int hold_viol = 0;
    int held_invalid = 0;
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    logic [7:0] held [$];
    logic pv = 1'b0;
    logic [7:0] pd = 8'h00;
    logic rv_valid, rv_busy, rv_done;
    logic [7:0] rv_data;
    logic [4:0] rv_sw;

    always @(posedge clock) cyc <= cyc + 1;

    // Observe accepted bytes, done pulses, stalls and hold-rule breaks.
    always @(negedge clock) begin
        if (!reset_n) begin
            pv = 1'b0;
        end else begin
            if (pv && (tx_valid !== 1'b1 || tx_data !== pd)) hold_viol++;
            if (tx_valid === 1'b1 && tx_ready === 1'b1) got.push_back(tx_data);
            if (tx_valid === 1'b1 && tx_ready === 1'b0) stall_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc - cyc0;
            end
            pv = (tx_valid === 1'b1) && (tx_ready === 1'b0);
            pd = tx_data;
        end
    end

    // Reference stream: optional header 0xA0+index, then the word MSB first.
    task automatic build_exp();
        exp_q.delete();
        for (int r = 0; r < 32; r++) begin
`ifdef REG_DUMP_HEADER_EN
            exp_q.push_back(8'hA0 + 8'(r));
`endif
            for (int b = 3; b >= 0; b--) exp_q.push_back(rf[r][8*b +: 8]);
        end
    endtask

    function automatic int first_diff();
        if (got.size() != exp_q.size()) return (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < got.size(); i++) if (got[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic randomize_rf();
        for (int r = 0; r < 32; r++) rf[r] = $urandom();
        rf[0] = 32'h0;
    endtask

    task automatic drive_dump(input bit rnd_stall, input int hold_at, input bit extra_starts,
                              input int wr_cyc, input int rst_at, output bit timed_out);
        int n;
        int post;
        int hold_left;
        bit hold_done;
        bit rst_done;
        got.delete();
        held.delete();
        held_invalid = 0;
        post = 0;
        hold_left = 0;
        hold_done = 0;
        rst_done = 0;
        timed_out = 1;
        @(posedge clock);
        #1;
        cyc0 = cyc;
        stall_cnt = 0;
        d_before = done_cnt;
        start = 1'b1;
        tx_ready = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clock);
            #1;
            n = cyc - cyc0;
            start = extra_starts && (n == 40 || n == DONE_CYC);
            if (n == wr_cyc) rf[9] = 32'hDEADBEEF;
            if (done_cnt != d_before) begin
                post++;
                if (post == 4) begin
                    timed_out = 0;
                    break;
                end
            end
            if (rst_at >= 0 && !rst_done && got.size() == rst_at && tx_valid === 1'b1) begin
                rst_done = 1;
                reset_n = 1'b0;
                #1;
                rv_valid = tx_valid;
                rv_busy  = busy;
                rv_done  = done;
                rv_data  = tx_data;
                rv_sw    = registerswitch;
                repeat (2) @(posedge clock);
                #1;
                reset_n = 1'b1;
                timed_out = 0;
                break;
            end
            if (hold_left > 0) begin
                tx_ready = 1'b0;
                held.push_back(tx_data);
                if (tx_valid !== 1'b1) held_invalid++;
                hold_left--;
            end else if (hold_at >= 0 && !hold_done && got.size() == hold_at && tx_valid === 1'b1) begin
                hold_done = 1;
                hold_left = 2;
                tx_ready = 1'b0;
                held.push_back(tx_data);
            end else begin
                tx_ready = rnd_stall ? ($urandom_range(3) != 0) : 1'b1;
            end
        end
        start = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", busy); end
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b want=0", done); end
        vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b want=0", tx_valid); end
        vecs++; if (tx_data !== 8'h00) begin errs++; $display("FAIL reset_data got=%h want=00", tx_data); end
        vecs++; if (registerswitch !== 5'd0) begin errs++; $display("FAIL reset_sw got=%0d want=0", registerswitch); end
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_full_dump();
        bit to;
        int d;
        int o;
        randomize_rf();
        rf[16] = 32'h12345678;
        build_exp();
        drive_dump(0, -1, 0, -1, -1, to);
        vecs++; if (to !== 1'b0) begin errs++; $display("FAIL full_timeout got=%b want=0", to); end
        vecs++; if (got.size() != TOTAL) begin errs++; $display("FAIL full_count got=%0d want=%0d", got.size(), TOTAL); end
        d = first_diff();
        vecs++; if (d != -1) begin errs++; $display("FAIL full_stream first diff at byte %0d", d); end
        o = 16 * BPR + WOFF;
        vecs++;
        if (got.size() != TOTAL || {got[o], got[o+1], got[o+2], got[o+3]} !== 32'h12345678) begin
            errs++; $display("FAIL full_reg16 count=%0d want bytes 12345678", got.size());
        end
        vecs++; if (done_cyc != DONE_CYC) begin errs++; $display("FAIL full_done_cycle got=%0d want=%0d", done_cyc, DONE_CYC); end
        vecs++; if (done_cnt - d_before != 1) begin errs++; $display("FAIL full_done_count got=%0d want=1", done_cnt - d_before); end
`ifdef REG_DUMP_HEADER_EN
        vecs++;
        if (got.size() != TOTAL || got[17*BPR] !== 8'hB1) begin
            errs++; $display("FAIL hdr_reg17 count=%0d want header B1", got.size());
        end
`endif
    endtask

    task automatic test_backpressure();
        bit to;
        int d;
        randomize_rf();
        rf[5] = 32'h11002233;
        build_exp();
        drive_dump(1, 5 * BPR + WOFF + 1, 0, -1, -1, to);
        vecs++; if (to !== 1'b0) begin errs++; $display("FAIL bp_timeout got=%b want=0", to); end
        vecs++; if (held.size() != 3) begin errs++; $display("FAIL bp_hold_len got=%0d want=3", held.size()); end
        for (int i = 0; i < held.size(); i++) begin
            vecs++; if (held[i] !== 8'h00) begin errs++; $display("FAIL bp_hold_data[%0d] got=%h want=00", i, held[i]); end
        end
        vecs++; if (held_invalid != 0) begin errs++; $display("FAIL bp_hold_valid drops got=%0d want=0", held_invalid); end
        d = first_diff();
        vecs++; if (d != -1) begin errs++; $display("FAIL bp_stream first diff at byte %0d (count %0d)", d, got.size()); end
        vecs++;
        if (done_cyc != DONE_CYC + stall_cnt) begin
            errs++; $display("FAIL bp_done_cycle got=%0d want=%0d", done_cyc, DONE_CYC + stall_cnt);
        end
        vecs++; if (hold_viol != 0) begin errs++; $display("FAIL bp_hold_rule violations got=%0d want=0", hold_viol); end
    endtask

    task automatic test_start_ignored();
        bit to;
        int d;
        randomize_rf();
        build_exp();
        drive_dump(0, -1, 1, -1, -1, to);
        vecs++; if (to !== 1'b0) begin errs++; $display("FAIL ign_timeout got=%b want=0", to); end
        vecs++; if (got.size() != TOTAL) begin errs++; $display("FAIL ign_count got=%0d want=%0d", got.size(), TOTAL); end
        d = first_diff();
        vecs++; if (d != -1) begin errs++; $display("FAIL ign_stream first diff at byte %0d", d); end
        vecs++; if (done_cnt - d_before != 1) begin errs++; $display("FAIL ign_done_count got=%0d want=1", done_cnt - d_before); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL ign_requeued busy got=%b want=0", busy); end
        vecs++; if (done_cyc != DONE_CYC) begin errs++; $display("FAIL ign_done_cycle got=%0d want=%0d", done_cyc, DONE_CYC); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int d;
        randomize_rf();
        build_exp();
        drive_dump(0, -1, 0, -1, 50, to);
        vecs++; if (rv_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b want=0", rv_valid); end
        vecs++; if (rv_busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b want=0", rv_busy); end
        vecs++; if (rv_done !== 1'b0) begin errs++; $display("FAIL rst_done got=%b want=0", rv_done); end
        vecs++; if (rv_data !== 8'h00) begin errs++; $display("FAIL rst_data got=%h want=00", rv_data); end
        vecs++; if (rv_sw !== 5'd0) begin errs++; $display("FAIL rst_sw got=%0d want=0", rv_sw); end
        vecs++; if (got.size() != 50) begin errs++; $display("FAIL rst_partial_count got=%0d want=50", got.size()); end
        repeat (6) @(posedge clock);
        #1;
        vecs++; if (done_cnt != d_before) begin errs++; $display("FAIL rst_no_done got=%0d want=0", done_cnt - d_before); end
        drive_dump(0, -1, 0, -1, -1, to);
        vecs++; if (to !== 1'b0) begin errs++; $display("FAIL rst_redo_timeout got=%b want=0", to); end
        d = first_diff();
        vecs++; if (d != -1) begin errs++; $display("FAIL rst_redo_stream first diff at byte %0d (count %0d)", d, got.size()); end
        vecs++; if (done_cyc != DONE_CYC) begin errs++; $display("FAIL rst_redo_done_cycle got=%0d want=%0d", done_cyc, DONE_CYC); end
    endtask

    task automatic test_snapshot();
        bit to;
        int d;
        int o;
        logic [31:0] old9;
        randomize_rf();
        old9 = rf[9];
        build_exp();
        o = 9 * BPR + WOFF;
        drive_dump(0, -1, 0, 1 + CPR * 9 + 1, -1, to);
        vecs++; if (to !== 1'b0) begin errs++; $display("FAIL snap_timeout got=%b want=0", to); end
        d = first_diff();
        vecs++; if (d != -1) begin errs++; $display("FAIL snap_stream first diff at byte %0d (count %0d)", d, got.size()); end
        vecs++;
        if (got.size() != TOTAL || {got[o], got[o+1], got[o+2], got[o+3]} !== old9) begin
            errs++; $display("FAIL snap_reg9 count=%0d want old value %h", got.size(), old9);
        end
        build_exp();
        drive_dump(0, -1, 0, -1, -1, to);
        vecs++;
        if (to !== 1'b0 || got.size() != TOTAL || {got[o], got[o+1], got[o+2], got[o+3]} !== 32'hDEADBEEF) begin
            errs++; $display("FAIL snap_reg9_new count=%0d timeout=%b want DEADBEEF", got.size(), to);
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_snapshot();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
